nd_nto1: RTL and testbench

ND_NTO1 -- requirements
Module: nd_nto1

---
 rtl/nd_nto1.sv | 180 ++++++++++++++++++
 tb/tb_nd_nto1.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_nto1.sv
// N-to-1 four-phase handshake concentrator: arbitrates NCH input channels into
// a message FIFO and drains it through a single four-phase output port.
module nd_nto1 #(
  parameter int NCH  = 4,
  parameter int FSZ  = 4,
  parameter int ASZ  = 6,
  parameter int DSZ  = 4,
  parameter int RSZ  = 4,
  parameter int PRIO = 0,
  localparam int MSZ = 2*ASZ + DSZ + RSZ,
  localparam int OSZ = $clog2(FSZ) + 1
) (
  input  logic               i_clk,
  input  logic               reset,
  output logic               ready,
  input  logic [NCH-1:0]     rcv_req,
  input  logic [NCH*MSZ-1:0] rcv_msg,
  output logic [NCH-1:0]     rcv_ack,
  output logic               snd_req,
  output logic [MSZ-1:0]     snd_msg,
  input  logic               snd_ack,
  output logic [OSZ-1:0]     occ
);

  // state    | meaning
  // IDLE     | waiting for a FIFO entry to present
  // REQ      | snd_req high, waiting for snd_ack
  // WAIT_LOW | snd_req dropped, waiting for snd_ack to fall
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_LOW} state_t;

  localparam int AW = $clog2(FSZ);
  localparam int RW = $clog2(NCH);
  localparam int SW = RW + 1;
  localparam logic [OSZ-1:0] OCC_FULL = OSZ'(FSZ);
  localparam logic [OSZ-1:0] OCC_ONE  = OSZ'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [RW-1:0]  CH_LAST  = RW'(NCH-1);
  localparam logic [RW-1:0]  CH_ONE   = RW'(1);
  localparam logic [SW-1:0]  CH_NUM   = SW'(NCH);

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [NCH-1:0]     ack_q, ack_d;
  logic               sreq_q, sreq_d;
  logic [MSZ-1:0]     smsg_q, smsg_d;
  logic [OSZ-1:0]     occ_q, occ_d;
  logic [AW-1:0]      wp_q, wp_d;
  logic [AW-1:0]      rp_q, rp_d;
  logic [RW-1:0]      rr_q, rr_d;
  logic [MSZ-1:0]     mem_q [FSZ];
  logic [MSZ-1:0]     mem_d [FSZ];

  logic [MSZ-1:0]     msg_ch [NCH];
  logic [NCH-1:0]     pending;
  logic [RW-1:0]      start;
  logic [SW-1:0]      sum;
  logic [RW-1:0]      cand;
  logic               found;
  logic [RW-1:0]      win;
  logic [MSZ-1:0]     win_msg;
  logic               push;
  logic               pop;

  // Arbitration: scan from the start index, wrapping modulo NCH.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      msg_ch[k] = rcv_msg[k*MSZ +: MSZ];
    end
    pending = rcv_req & ~ack_q;
    start   = (PRIO != 0) ? '0 : rr_q;
    found   = 1'b0;
    win     = '0;
    win_msg = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = {1'b0, start} + SW'(i);
      if (sum >= CH_NUM) sum = sum - CH_NUM;
      cand = sum[RW-1:0];
      if (!found && pending[cand]) begin
        found   = 1'b1;
        win     = cand;
        win_msg = msg_ch[cand];
      end
    end
  end

  // Output stage FSM; full/empty both judged on start-of-cycle occupancy.
  always_comb begin
    state_d = state_q;
    sreq_d  = sreq_q;
    smsg_d  = smsg_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready_q && (occ_q != '0)) begin
          pop     = 1'b1;
          smsg_d  = mem_q[rp_q];
          sreq_d  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (snd_ack) begin
          sreq_d  = 1'b0;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!snd_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    push    = ready_q && (occ_q != OCC_FULL) && found;
    ready_d = 1'b1;

    mem_d = mem_q;
    if (push) mem_d[wp_q] = win_msg;
    wp_d = push ? wp_q + PTR_ONE : wp_q;
    rp_d = pop  ? rp_q + PTR_ONE : rp_q;

    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_ONE;
    else if (!push && pop) occ_d = occ_q - OCC_ONE;

    rr_d = rr_q;
    if (push && (PRIO == 0)) rr_d = (win == CH_LAST) ? '0 : win + CH_ONE;

    // An ack drops once its request has been seen low.
    ack_d = ack_q & rcv_req;
    if (push) ack_d[win] = 1'b1;

    if (!ready_q) begin
      state_d = ST_IDLE;
      sreq_d  = 1'b0;
      smsg_d  = '0;
      occ_d   = '0;
      wp_d    = '0;
      rp_d    = '0;
      rr_d    = '0;
      ack_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      ack_q   <= '0;
      sreq_q  <= 1'b0;
      smsg_q  <= '0;
      occ_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      sreq_q  <= sreq_d;
      smsg_q  <= smsg_d;
      occ_q   <= occ_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) mem_q <= mem_d;
  end

  assign ready   = ready_q;
  assign rcv_ack = ack_q;
  assign snd_req = sreq_q;
  assign snd_msg = smsg_q;
  assign occ     = occ_q;

endmodule

// File: tb/tb_nd_nto1.sv
// Bench for nd_nto1: directed vector table plus handshake-model sequences for
// fairness, FIFO wrap, full back-pressure, mid-run reset and fixed priority.
module tb_nd_nto1;
  localparam int NCH = 4;
  localparam int FSZ = 4;
  localparam int MSZ = 20;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic             reset;
  logic             ready, snd_req, snd_ack;
  logic [3:0]       rcv_req, rcv_ack;
  logic [79:0]      rcv_msg;
  logic [19:0]      snd_msg;
  logic [2:0]       occ;

  logic             ready_f, snd_req_f, snd_ack_f;
  logic [3:0]       rcv_req_f, rcv_ack_f;
  logic [79:0]      rcv_msg_f;
  logic [19:0]      snd_msg_f;
  logic [2:0]       occ_f;

  nd_nto1 #(.NCH(NCH), .FSZ(FSZ), .ASZ(6), .DSZ(4), .RSZ(4), .PRIO(0)) u_rr (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv_req(rcv_req), .rcv_msg(rcv_msg), .rcv_ack(rcv_ack),
    .snd_req(snd_req), .snd_msg(snd_msg), .snd_ack(snd_ack), .occ(occ));

  nd_nto1 #(.NCH(NCH), .FSZ(FSZ), .ASZ(6), .DSZ(4), .RSZ(4), .PRIO(1)) u_fp (
    .i_clk(i_clk), .reset(reset), .ready(ready_f),
    .rcv_req(rcv_req_f), .rcv_msg(rcv_msg_f), .rcv_ack(rcv_ack_f),
    .snd_req(snd_req_f), .snd_msg(snd_msg_f), .snd_ack(snd_ack_f), .occ(occ_f));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mkmsg(input int k, input int j);
    return {4'hC, k[7:0], j[7:0]};
  endfunction

  // Handshake models: senders on u_rr channels and an echoing sink.
  logic [3:0]  auto_en = '0;
  logic        auto_sink = 1'b0;
  int          left [4];
  int          sent [4];
  logic [3:0]  prev_ack = '0;
  logic        prev_sreq = 1'b0;
  int          ack_cnt = 0;
  int          grant_ch [$];
  logic [19:0] grant_msg [$];
  logic [19:0] out_msg [$];

  task automatic tick();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (rcv_ack[k] && !prev_ack[k]) begin
        grant_ch.push_back(k);
        grant_msg.push_back(rcv_msg[k*MSZ +: MSZ]);
        ack_cnt++;
      end
    end
    if (snd_req && !prev_sreq) out_msg.push_back(snd_msg);
    prev_ack  = rcv_ack;
    prev_sreq = snd_req;
    for (int k = 0; k < 4; k++) begin
      if (auto_en[k]) begin
        if (rcv_req[k] && rcv_ack[k]) rcv_req[k] = 1'b0;
        else if (!rcv_req[k] && !rcv_ack[k] && left[k] > 0) begin
          rcv_msg[k*MSZ +: MSZ] = mkmsg(k, sent[k]);
          rcv_req[k] = 1'b1;
          sent[k]++;
          left[k]--;
        end
      end
    end
    if (auto_sink) snd_ack = snd_req;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       sack;
    logic       e_ready;
    logic [3:0] e_ack;
    logic       e_sreq;
    int         e_occ;   // -1: not checked
    int         e_msg;   // -1: not checked
  } vec_t;

  vec_t tbl [20];

  initial begin
    // channel messages for the table phase: ch0 11, ch1 22, ch2 A5, ch3 33
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1, -1};
    tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1, -1};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0,  0, 0};
    tbl[3]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0,  1, 0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1,  0, 32'hA5};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0,  0, 32'hA5};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0,  0, 32'hA5};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b0,  1, 32'hA5};
    tbl[8]  = '{1'b0, 4'b0111, 1'b0, 1'b1, 4'b0001, 1'b1,  1, 32'h33};
    tbl[9]  = '{1'b0, 4'b0110, 1'b1, 1'b1, 4'b0010, 1'b0,  2, 32'h33};
    tbl[10] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0,  3, 32'h33};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1,  2, 32'h11};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0,  2, 32'h11};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0,  2, -1};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1,  1, 32'h22};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0,  1, -1};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0,  1, -1};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1,  0, 32'hA5};
    tbl[18] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0,  0, -1};
    tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0,  0, -1};

    reset     = 1'b1;
    rcv_req   = '0;
    snd_ack   = 1'b0;
    rcv_msg   = {20'h00033, 20'h000A5, 20'h00022, 20'h00011};
    rcv_req_f = '0;
    snd_ack_f = 1'b0;
    rcv_msg_f = {20'h00F33, 20'h00F22, 20'h00F11, 20'h00F00};
    for (int k = 0; k < 4; k++) begin left[k] = 0; sent[k] = 0; end

    for (int v = 0; v < 20; v++) begin
      reset   = tbl[v].rst;
      rcv_req = tbl[v].req;
      snd_ack = tbl[v].sack;
      tick();
      chk($sformatf("v%0d_ready", v), 32'(ready), 32'(tbl[v].e_ready));
      chk($sformatf("v%0d_ack", v), 32'(rcv_ack), 32'(tbl[v].e_ack));
      chk($sformatf("v%0d_sreq", v), 32'(snd_req), 32'(tbl[v].e_sreq));
      if (tbl[v].e_occ >= 0) chk($sformatf("v%0d_occ", v), 32'(occ), tbl[v].e_occ);
      if (tbl[v].e_msg >= 0) chk($sformatf("v%0d_msg", v), 32'(snd_msg), tbl[v].e_msg);
    end

    // Fairness and wrap: 3*FSZ messages, all channels re-requesting, rr from 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_ready", 32'(ready), 32'd1);
    grant_ch.delete();
    grant_msg.delete();
    out_msg.delete();
    ack_cnt = 0;
    for (int k = 0; k < 4; k++) begin left[k] = 3; sent[k] = 0; end
    auto_en   = 4'b1111;
    auto_sink = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (out_msg.size() == 12 && !snd_req && !snd_ack && occ == 3'd0) break;
      tick();
    end
    tick();
    tick();
    chk("rr_grant_count", 32'(grant_ch.size()), 32'd12);
    chk("wrap_out_count", 32'(out_msg.size()), 32'd12);
    for (int i = 0; i < 12 && i < grant_ch.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(grant_ch[i]), 32'(i % 4));
    for (int i = 0; i < 12 && i < out_msg.size(); i++)
      chk($sformatf("wrap_out%0d", i), 32'(out_msg[i]), 32'(mkmsg(i % 4, i / 4)));
    chk("wrap_occ0", 32'(occ), 32'd0);

    // Full: sink stalled in REQ, six requests, five acks expected.
    auto_sink = 1'b0;
    snd_ack   = 1'b0;
    ack_cnt   = 0;
    left[0] = 2; left[1] = 2; left[2] = 1; left[3] = 1;
    repeat (40) tick();
    chk("full_acks", 32'(ack_cnt), 32'd5);
    chk("full_occ", 32'(occ), 32'd4);
    chk("full_sreq", 32'(snd_req), 32'd1);
    chk("full_no_ack", 32'(rcv_ack), 32'd0);
    chk("full_req_waiting", 32'(rcv_req != 4'b0000), 32'd1);
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
    for (int c = 0; c < 20 && ack_cnt < 6; c++) tick();
    chk("full_sixth_ack", 32'(ack_cnt), 32'd6);
    auto_sink = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (occ == 3'd0 && !snd_req && !snd_ack && rcv_req == 4'b0000) break;
      tick();
    end
    tick();
    tick();
    chk("full_drain_occ", 32'(occ), 32'd0);

    // Mid-run reset with occ=3, snd_req=1 and an ack high.
    auto_sink = 1'b0;
    snd_ack   = 1'b0;
    ack_cnt   = 0;
    left[1] = 2; left[2] = 1;
    repeat (25) tick();
    chk("pre_rst_acks", 32'(ack_cnt), 32'd3);
    chk("pre_rst_occ2", 32'(occ), 32'd2);
    chk("pre_rst_sreq", 32'(snd_req), 32'd1);
    auto_en = 4'b0000;
    rcv_req[0] = 1'b1;
    tick();
    chk("pre_rst_ack0", 32'(rcv_ack), 32'b0001);
    chk("pre_rst_occ3", 32'(occ), 32'd3);
    reset = 1'b1;
    tick();
    chk("in_rst_ready", 32'(ready), 32'd0);
    chk("in_rst_sreq", 32'(snd_req), 32'd0);
    chk("in_rst_ack", 32'(rcv_ack), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_occ", 32'(occ), 32'd0);
    chk("post_rst_sreq", 32'(snd_req), 32'd0);
    chk("post_rst_msg", 32'(snd_msg), 32'd0);
    rcv_req = 4'b1111;
    tick();
    chk("post_rst_rr0", 32'(rcv_ack), 32'b0001);
    rcv_req = 4'b0000;
    tick();

    // Fixed priority on the PRIO=1 instance.
    rcv_req_f = 4'b1010;
    tick();
    chk("fp_first", 32'(rcv_ack_f), 32'b0010);
    rcv_req_f = 4'b1000;
    tick();
    chk("fp_second", 32'(rcv_ack_f), 32'b1000);
    rcv_req_f = 4'b0010;
    tick();
    chk("fp_single", 32'(rcv_ack_f), 32'b0010);
    rcv_req_f = 4'b0000;
    tick();
    chk("fp_release", 32'(rcv_ack_f), 32'b0000);
    rcv_req_f = 4'b0101;
    tick();
    chk("fp_lowest_wins", 32'(rcv_ack_f), 32'b0001);
    chk("fp_occ", 32'(occ_f), 32'd3);
    chk("fp_sreq", 32'(snd_req_f), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
